// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo-N up/down counter with enable, direction,
// parallel load, wrap/saturate mode, terminal-count and overflow flags.
// Every flop is clocked directly by clk, so there are no derived clocks
// and no ripple skew. It cascades by driving the next stage's en from tc,
// with both stages on the same clk.
module sync_updown_counter #(
   parameter int unsigned     WIDTH    = 4,    // 1..32
   parameter longint unsigned MODULUS  = 16,   // 2..2**WIDTH
   parameter bit              SATURATE = 1'b0  // 0 = wrap, 1 = hold at bounds
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   // Arithmetic is carried one bit wider than the count. This keeps
   // MODULUS = 2**WIDTH legal: its top value, and the load clamp against it,
   // still fit without aliasing.
   localparam int unsigned     AW      = WIDTH + 1;
   localparam logic [AW-1:0]   TOP_EXT = AW'(MODULUS - 1);
   localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);

   logic [AW-1:0]    q_ext;
   logic [AW-1:0]    din_ext;
   logic             at_top;
   logic             at_bot;
   logic             bound_event;
   logic [WIDTH-1:0] q_next;

   assign q_ext   = {1'b0, q};
   assign din_ext = {1'b0, din};
   assign at_top  = (q_ext == TOP_EXT);
   assign at_bot  = (q_ext == '0);

   // Terminal count is combinational, so a downstream stage sees it in the same cycle.
   assign tc = en & ((up & at_top) | (~up & at_bot));

   // A load always takes precedence, so a bound event needs en with no load.
   assign bound_event = en & ~load & tc;

   assign qbar = ~q;

   // Next count value. Load clamps to the top of range; counting either wraps or holds at a bound.
   always_comb begin
      q_next = q;
      if (load) begin
         if (din_ext > TOP_EXT) begin
            q_next = TOP;
         end else begin
            q_next = din;
         end
      end else if (en) begin
         if (up) begin
            if (at_top) begin
               q_next = SATURATE ? q : '0;
            end else begin
               q_next = WIDTH'(q_ext + AW'(1));
            end
         end else begin
            if (at_bot) begin
               q_next = SATURATE ? q : TOP;
            end else begin
               q_next = WIDTH'(q_ext - AW'(1));
            end
         end
      end
   end

   // State register. Reset clears everything and discards any pending flag update.
   // On the same edge, a bound event's set beats clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= bound_event;
         ovf  <= bound_event | (ovf & ~clr);
      end
   end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter. It covers three configurations:
// modulo-10 wrap, modulo-10 saturate, and two cascaded modulo-16 stages.
module tb_sync_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // ---------------- modulo-10 wrap instance ----------------
   logic       w_reset, w_en, w_up, w_load, w_clr;
   logic [3:0] w_din, w_q, w_qbar;
   logic       w_tc, w_wrap, w_ovf;

   sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(w_reset), .en(w_en), .up(w_up), .load(w_load),
      .din(w_din), .clr(w_clr), .q(w_q), .qbar(w_qbar), .tc(w_tc),
      .wrap(w_wrap), .ovf(w_ovf)
   );

   // ---------------- modulo-10 saturate instance ----------------
   logic       s_reset, s_en, s_up, s_load, s_clr;
   logic [3:0] s_din, s_q, s_qbar;
   logic       s_tc, s_wrap, s_ovf;

   sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(s_reset), .en(s_en), .up(s_up), .load(s_load),
      .din(s_din), .clr(s_clr), .q(s_q), .qbar(s_qbar), .tc(s_tc),
      .wrap(s_wrap), .ovf(s_ovf)
   );

   // ---------------- cascaded modulo-16 pair ----------------
   logic       c_reset, c_en, c_up;
   logic [3:0] lo_q, lo_qbar, hi_q, hi_qbar;
   logic       lo_tc, lo_wrap, lo_ovf, hi_tc, hi_wrap, hi_ovf;

   sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
      .clk(clk), .reset(c_reset), .en(c_en), .up(c_up), .load(1'b0),
      .din(4'd0), .clr(1'b0), .q(lo_q), .qbar(lo_qbar), .tc(lo_tc),
      .wrap(lo_wrap), .ovf(lo_ovf)
   );

   sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
      .clk(clk), .reset(c_reset), .en(lo_tc), .up(c_up), .load(1'b0),
      .din(4'd0), .clr(1'b0), .q(hi_q), .qbar(hi_qbar), .tc(hi_tc),
      .wrap(hi_wrap), .ovf(hi_ovf)
   );

   // Compare one observed value against its expected value and keep the tallies.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one rising edge, then settle so that outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      w_reset = 1; w_en = 0; w_up = 1; w_load = 0; w_clr = 0; w_din = 0;
      s_reset = 1; s_en = 0; s_up = 1; s_load = 0; s_clr = 0; s_din = 0;
      c_reset = 1; c_en = 0; c_up = 1;
      step();

      // ---- reset state ----
      chk("rst_q",    32'(w_q),    32'd0);
      chk("rst_qbar", 32'(w_qbar), 32'hF);
      chk("rst_wrap", 32'(w_wrap), 32'd0);
      chk("rst_ovf",  32'(w_ovf),  32'd0);
      chk("rst_tc",   32'(w_tc),   32'd0);
      w_en = 1; w_up = 0; #1;
      chk("rst_tc_down", 32'(w_tc), 32'd1);
      w_up = 1; #1;
      chk("rst_tc_up", 32'(w_tc), 32'd0);

      // ---- 1: count up through the wrap: 1..9,0,1,2 ----
      w_reset = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("up_q",    32'(w_q),    32'(i % 10));
         chk("up_qbar", 32'(w_qbar), 32'(4'hF ^ 4'(i % 10)));
         chk("up_tc",   32'(w_tc),   32'((i % 10) == 9));
         chk("up_wrap", 32'(w_wrap), 32'(i == 10));
         chk("up_ovf",  32'(w_ovf),  32'(i >= 10));
      end

      // ---- 2: count down from 0 ----
      w_reset = 1; step();
      w_reset = 0; w_up = 0; #1;
      chk("dn_tc0", 32'(w_tc), 32'd1);
      step();
      chk("dn_q9",    32'(w_q),    32'd9);
      chk("dn_wrap9", 32'(w_wrap), 32'd1);
      chk("dn_ovf9",  32'(w_ovf),  32'd1);
      chk("dn_tc9",   32'(w_tc),   32'd0);
      step();
      chk("dn_q8",    32'(w_q),    32'd8);
      chk("dn_wrap8", 32'(w_wrap), 32'd0);
      step();
      chk("dn_q7", 32'(w_q), 32'd7);

      // ---- 4: load clamps above range, overrides en, is not a bound event ----
      w_load = 1; w_din = 4'd13; w_up = 1;
      step();
      chk("ld13_q",    32'(w_q),    32'd9);
      chk("ld13_wrap", 32'(w_wrap), 32'd0);
      chk("ld13_ovf",  32'(w_ovf),  32'd1);
      w_din = 4'd5;
      step();
      chk("ld5_q",    32'(w_q),    32'd5);
      chk("ld5_wrap", 32'(w_wrap), 32'd0);

      // clr with the counter idle clears ovf only
      w_load = 0; w_en = 0; w_clr = 1;
      step();
      chk("clr_ovf", 32'(w_ovf), 32'd0);
      chk("clr_q",   32'(w_q),   32'd5);
      w_clr = 0;

      // ---- clr and bound event on the same edge: the set wins ----
      w_load = 1; w_din = 4'd9; step();
      w_load = 0; w_en = 1; w_up = 1; w_clr = 1;
      step();
      chk("clrset_q",    32'(w_q),    32'd0);
      chk("clrset_wrap", 32'(w_wrap), 32'd1);
      chk("clrset_ovf",  32'(w_ovf),  32'd1);
      w_clr = 0;

      // ---- direction change with no dead cycle ----
      w_up = 0; step();
      chk("dir_q9", 32'(w_q), 32'd9);
      w_up = 1; step();
      chk("dir_q0", 32'(w_q), 32'd0);
      chk("dir_wrap", 32'(w_wrap), 32'd1);

      // ---- 5: reset beats load and a pending bound event ----
      w_en = 0; w_load = 1; w_din = 4'd7; step();
      chk("pre_rst_q", 32'(w_q), 32'd7);
      w_load = 0; w_en = 1; step(); step();
      chk("pre_rst_q9", 32'(w_q), 32'd9);
      w_reset = 1; w_load = 1; w_din = 4'd3;
      step();
      chk("midrst_q",    32'(w_q),    32'd0);
      chk("midrst_qbar", 32'(w_qbar), 32'hF);
      chk("midrst_wrap", 32'(w_wrap), 32'd0);
      chk("midrst_ovf",  32'(w_ovf),  32'd0);
      w_reset = 0; w_load = 0; w_en = 0;

      // ---- 3: saturate mode holds at the bound and re-raises wrap ----
      s_reset = 0; s_en = 1; s_up = 1;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("sat_q",    32'(s_q),    32'((i > 9) ? 9 : i));
         chk("sat_tc",   32'(s_tc),   32'(i >= 9));
         chk("sat_wrap", 32'(s_wrap), 32'(i >= 10));
         chk("sat_ovf",  32'(s_ovf),  32'(i >= 10));
      end
      s_en = 0; step();
      chk("sat_idle_wrap", 32'(s_wrap), 32'd0);
      chk("sat_idle_ovf",  32'(s_ovf),  32'd1);
      s_clr = 1; step();
      chk("sat_clr_ovf", 32'(s_ovf), 32'd0);
      chk("sat_clr_q",   32'(s_q),   32'd9);
      s_clr = 0;
      s_load = 1; s_din = 4'd0; step();
      s_load = 0; s_en = 1; s_up = 0; step();
      chk("sat_dn_q",    32'(s_q),    32'd0);
      chk("sat_dn_wrap", 32'(s_wrap), 32'd1);
      chk("sat_dn_ovf",  32'(s_ovf),  32'd1);
      s_en = 0;

      // ---- 6: cascaded modulo-16 stages count 0..255 then 0 ----
      chk("cas_rst", 32'({hi_q, lo_q}), 32'd0);
      c_reset = 0; c_en = 1; c_up = 1;
      for (int i = 1; i <= 256; i++) begin
         step();
         chk("cas_cnt",   32'({hi_q, lo_q}), 32'(i % 256));
         chk("cas_lo_tc", 32'(lo_tc),        32'((i % 16) == 15));
      end
      chk("cas_hi_wrap", 32'(hi_wrap), 32'd1);
      chk("cas_hi_ovf",  32'(hi_ovf),  32'd1);
      c_en = 0; step();
      chk("cas_hold", 32'({hi_q, lo_q}), 32'd0);
      chk("cas_hold_wrap", 32'(hi_wrap), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
